// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler slice.
package uart_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int GAP_W      = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      GAP   = 3'd4
   } sched_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pri points at the requester favoured next.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       en,
   output logic [1:0] grant,
   output logic       pri
);

   // Grant the favoured requester if valid, otherwise the other one.
   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (pri == 1'b0) begin
            grant[0] = valid[0];
            grant[1] = valid[1] & ~valid[0];
         end else begin
            grant[1] = valid[1];
            grant[0] = valid[0] & ~valid[1];
         end
      end else begin
         grant = 2'b00;
      end
   end

   // After a grant the loser becomes favoured; otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         pri <= 1'b0;
      end else if (grant[0]) begin
         pri <= 1'b1;
      end else if (grant[1]) begin
         pri <= 1'b0;
      end else begin
         pri <= pri;
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates two byte producers onto the TX FIFO and paces FIFO pops into
// the serializer, one frame in flight, with a programmable idle gap.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int GAP_CYC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   output logic              fifo_wr,
   output logic [DATA_W-1:0] fifo_wdata,
   output logic              fifo_rd,
   input  logic [DATA_W-1:0] fifo_rdata,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_din,
   input  logic              tx_done_tick,
   output logic              busy
);

   localparam logic             HAS_GAP  = (GAP_CYC != 0);
   localparam logic [GAP_W-1:0] GAP_LOAD = HAS_GAP ? GAP_W'(GAP_CYC - 1) : '0;

   logic [1:0]       grant_s;
   logic             pri_s;
   sched_state_t     state_r, state_next_s;
   logic [GAP_W-1:0] gap_r, gap_next_s;
   logic             pop_s;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .valid ({req1_valid, req0_valid}),
      .en    (~fifo_full),
      .grant (grant_s),
      .pri   (pri_s)
   );

   assign req0_ready = grant_s[0];
   assign req1_ready = grant_s[1];
   assign fifo_wr    = grant_s[0] | grant_s[1];
   assign fifo_wdata = grant_s[1] ? req1_data : req0_data;
   // Pop is only ever issued from IDLE; masking with reset keeps it quiet
   // while the shared FIFO controller is itself being cleared.
   assign fifo_rd    = pop_s & ~reset;

   // Frame pacing: next state, gap counter and pop decision.
   always_comb begin
      state_next_s = state_r;
      gap_next_s   = gap_r;
      pop_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (!fifo_empty) begin
               pop_s        = 1'b1;
               state_next_s = START;
            end else begin
               state_next_s = IDLE;
            end
         end
         START: state_next_s = WAIT;
         WAIT: begin
            if (tx_done_tick) begin
               if (HAS_GAP) begin
                  state_next_s = GAP;
                  gap_next_s   = GAP_LOAD;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = WAIT;
            end
         end
         GAP: begin
            if (gap_r == {GAP_W{1'b0}}) begin
               state_next_s = IDLE;
            end else begin
               gap_next_s = gap_r - {{(GAP_W-1){1'b0}}, 1'b1};
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State, counter and registered transmitter-facing outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         gap_r    <= {GAP_W{1'b0}};
         tx_din   <= {DATA_W{1'b0}};
         tx_start <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         gap_r    <= gap_next_s;
         tx_start <= (state_next_s == START);
         busy     <= (state_next_s != IDLE);
         if (pop_s) begin
            tx_din <= fifo_rdata;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed, self-checking bench for uart_tx_sched with GAP_CYC=3.
module tb_uart_tx_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [7:0] req0_data, req1_data;
   logic       fifo_full, fifo_empty, fifo_wr, fifo_rd;
   logic [7:0] fifo_wdata, fifo_rdata, tx_din;
   logic       tx_start, tx_done_tick, busy;

   int n_vec = 0;
   int n_err = 0;

   uart_tx_sched #(.DATA_W(8), .GAP_CYC(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_valid   (req0_valid),
      .req0_data    (req0_data),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_data    (req1_data),
      .req1_ready   (req1_ready),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .fifo_wr      (fifo_wr),
      .fifo_wdata   (fifo_wdata),
      .fifo_rd      (fifo_rd),
      .fifo_rdata   (fifo_rdata),
      .tx_start     (tx_start),
      .tx_din       (tx_din),
      .tx_done_tick (tx_done_tick),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      fifo_full = 1'b0; fifo_empty = 1'b1; tx_done_tick = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data = 8'h00; req1_data = 8'h00; fifo_full = 1'b0;
      fifo_empty = 1'b1; fifo_rdata = 8'h00; tx_done_tick = 1'b0;
      tick(); tick();
      @(negedge clk);
      n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (tx_din !== 8'h00) begin n_err++; $display("FAIL reset_tx_din got %h want 00", tx_din); end
      n_vec++; if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL reset_fifo_rd got %b want 0", fifo_rd); end
      n_vec++; if (fifo_wr !== 1'b0) begin n_err++; $display("FAIL reset_fifo_wr got %b want 0", fifo_wr); end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_data = 8'hA5; fifo_empty = 1'b1;
      @(negedge clk);
      n_vec++; if (fifo_wr !== 1'b1 || fifo_wdata !== 8'hA5 || req0_ready !== 1'b1)
         begin n_err++; $display("FAIL single_write got wr=%b d=%h rdy=%b want 1 a5 1", fifo_wr, fifo_wdata, req0_ready); end
      n_vec++; if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL single_no_rd_W got %b want 0", fifo_rd); end
      tick();
      req0_valid = 1'b0; fifo_empty = 1'b0; fifo_rdata = 8'hA5;
      @(negedge clk);
      n_vec++; if (fifo_rd !== 1'b1) begin n_err++; $display("FAIL single_rd_W1 got %b want 1", fifo_rd); end
      n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_start_W1 got %b want 0", tx_start); end
      tick();
      fifo_empty = 1'b1;
      @(negedge clk);
      n_vec++; if (tx_start !== 1'b1 || tx_din !== 8'hA5 || busy !== 1'b1)
         begin n_err++; $display("FAIL single_start_W2 got st=%b din=%h busy=%b want 1 a5 1", tx_start, tx_din, busy); end
      n_vec++; if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL single_rd_W2 got %b want 0", fifo_rd); end
      tick();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         n_vec++; if (tx_start !== 1'b0 || busy !== 1'b1)
            begin n_err++; $display("FAIL single_wait[%0d] got st=%b busy=%b want 0 1", i, tx_start, busy); end
         tick();
      end
      tx_done_tick = 1'b1;
      @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_done_busy got %b want 1", busy); end
      tick();
      tx_done_tick = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_gap[%0d] busy got %b want 1", i, busy); end
         tick();
      end
      @(negedge clk);
      n_vec++; if (busy !== 1'b0 || tx_start !== 1'b0)
         begin n_err++; $display("FAIL single_idle got busy=%b st=%b want 0 0", busy, tx_start); end
      tick();
   endtask

   task automatic test_contention();
      logic [7:0] exp_d [4];
      logic [7:0] d0, d1;
      exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h11; exp_d[3] = 8'h21;
      do_reset();
      d0 = 8'h10; d1 = 8'h20;
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1'b1; req0_data = d0; req1_valid = 1'b1; req1_data = d1;
         @(negedge clk);
         n_vec++; if (fifo_wr !== 1'b1 || fifo_wdata !== exp_d[i])
            begin n_err++; $display("FAIL contention_data[%0d] got wr=%b d=%h want 1 %h", i, fifo_wr, fifo_wdata, exp_d[i]); end
         n_vec++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1))
            begin n_err++; $display("FAIL contention_ready[%0d] got %b%b want %b%b", i, req1_ready, req0_ready, (i % 2 == 1), (i % 2 == 0)); end
         if (i % 2 == 0) d0 = d0 + 8'h01; else d1 = d1 + 8'h01;
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      fifo_full = 1'b1; req1_valid = 1'b1; req1_data = 8'h77;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_vec++; if (req1_ready !== 1'b0 || fifo_wr !== 1'b0 || req0_ready !== 1'b0)
            begin n_err++; $display("FAIL full_hold[%0d] got rdy1=%b wr=%b want 0 0", i, req1_ready, fifo_wr); end
         tick();
      end
      fifo_full = 1'b0;
      @(negedge clk);
      n_vec++; if (req1_ready !== 1'b1 || fifo_wr !== 1'b1 || fifo_wdata !== 8'h77)
         begin n_err++; $display("FAIL full_release got rdy1=%b wr=%b d=%h want 1 1 77", req1_ready, fifo_wr, fifo_wdata); end
      tick();
      req1_valid = 1'b0;
   endtask

   task automatic test_empty_boundary();
      req0_valid = 1'b1; req0_data = 8'h3C; fifo_empty = 1'b1;
      @(negedge clk);
      n_vec++; if (fifo_wr !== 1'b1 || fifo_rd !== 1'b0)
         begin n_err++; $display("FAIL empty_same_cycle got wr=%b rd=%b want 1 0", fifo_wr, fifo_rd); end
      tick();
      req0_valid = 1'b0; fifo_empty = 1'b0; fifo_rdata = 8'h3C;
      @(negedge clk);
      n_vec++; if (fifo_rd !== 1'b1) begin n_err++; $display("FAIL empty_next_pop got %b want 1", fifo_rd); end
      tick();
      fifo_empty = 1'b1;
      @(negedge clk);
      n_vec++; if (tx_start !== 1'b1 || tx_din !== 8'h3C)
         begin n_err++; $display("FAIL empty_start got st=%b din=%h want 1 3c", tx_start, tx_din); end
      tick();
      tx_done_tick = 1'b1;
      @(negedge clk);
      tick();
      tx_done_tick = 1'b0;
      tick(); tick(); tick();
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL empty_back_idle got busy=%b want 0", busy); end
      tick();
   endtask

   task automatic test_spurious_done();
      tx_done_tick = 1'b1; fifo_empty = 1'b1;
      @(negedge clk);
      tick();
      tx_done_tick = 1'b0;
      @(negedge clk);
      n_vec++; if (busy !== 1'b0 || tx_start !== 1'b0)
         begin n_err++; $display("FAIL spur_idle got busy=%b st=%b want 0 0", busy, tx_start); end
      tick();
      fifo_empty = 1'b0; fifo_rdata = 8'h5A;
      @(negedge clk);
      tick();
      fifo_empty = 1'b1; tx_done_tick = 1'b1;
      @(negedge clk);
      n_vec++; if (tx_start !== 1'b1 || tx_din !== 8'h5A)
         begin n_err++; $display("FAIL spur_start got st=%b din=%h want 1 5a", tx_start, tx_din); end
      tick();
      tx_done_tick = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_vec++; if (busy !== 1'b1 || tx_start !== 1'b0)
            begin n_err++; $display("FAIL spur_wait[%0d] got busy=%b st=%b want 1 0", i, busy, tx_start); end
         tick();
      end
   endtask

   task automatic test_reset_mid_wait();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req0_valid = 1'b1; req0_data = 8'h44; req1_valid = 1'b1; req1_data = 8'h55;
      @(negedge clk);
      n_vec++; if (busy !== 1'b0 || tx_start !== 1'b0 || tx_din !== 8'h00)
         begin n_err++; $display("FAIL midreset_state got busy=%b st=%b din=%h want 0 0 00", busy, tx_start, tx_din); end
      n_vec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || fifo_wdata !== 8'h44)
         begin n_err++; $display("FAIL midreset_pri got rdy=%b%b d=%h want 01 44", req1_ready, req0_ready, fifo_wdata); end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_empty_boundary();
      test_spurious_done();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Scheduler between the UART transmit FIFO and the UART transmitter. It arbitrates two byte producers, a host register port and a loopback/echo path, onto the single write port of the TX FIFO. It drains the FIFO into the transmitter one frame at a time and inserts a programmable idle gap between frames. It sits between the TX FIFO controller/register file and the `uart_tx` serializer.

## Interface
Parameters:
- `DATA_W`, default 8: byte width on all data ports.
- `GAP_CYC`, default 0: idle cycles inserted after each `tx_done_tick` before the next pop. Legal range is 0..255.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `req0_valid`, in, 1: requester 0 has a byte.
- `req0_data`, in, DATA_W: requester 0 byte.
- `req0_ready`, out, 1: requester 0 byte accepted this cycle.
- `req1_valid`, in, 1: requester 1 has a byte.
- `req1_data`, in, DATA_W: requester 1 byte.
- `req1_ready`, out, 1: requester 1 byte accepted this cycle.
- `fifo_full`, in, 1: TX FIFO full (registered in the FIFO controller).
- `fifo_empty`, in, 1: TX FIFO empty (registered in the FIFO controller).
- `fifo_wr`, out, 1: FIFO write strobe.
- `fifo_wdata`, out, DATA_W: FIFO write data.
- `fifo_rd`, out, 1: FIFO pop strobe.
- `fifo_rdata`, in, DATA_W: FIFO head byte; valid whenever `fifo_empty`=0.
- `tx_start`, out, 1: one-cycle start pulse to the transmitter.
- `tx_din`, out, DATA_W: byte to transmit; registered.
- `tx_done_tick`, in, 1: transmitter finished the frame.
- `busy`, out, 1: FSM not in IDLE.

## Operation
Write side (combinational, round-robin):
- Priority pointer `pri` is registered; 0 favours req0.
- A write happens when (`req0_valid` | `req1_valid`) & ~`fifo_full`.
- The winner is the favoured requester if it is valid; otherwise the other one.
- `fifo_wr` = 1, `fifo_wdata` = winner data, and only the winner's `reqN_ready` = 1.
- After a write, `pri` points to the loser. If no write occurs, `pri` holds.
- When `fifo_full`=1, both ready signals are 0 and `fifo_wr`=0. Requesters hold valid and data until ready.

Read side FSM (states IDLE, LOAD, START, WAIT, GAP):
- IDLE: if ~`fifo_empty`, assert `fifo_rd` and register `tx_din` ← `fifo_rdata` at this edge, then go to START.
- START: `tx_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: hold until `tx_done_tick`. Then go to GAP with counter ← `GAP_CYC`-1 if `GAP_CYC`>0; otherwise go to IDLE.
- GAP: decrement the counter each cycle; at 0 go to IDLE.
- LOAD is reserved in the enum and unreachable.
- Only one frame is ever outstanding. `tx_done_tick` outside WAIT is ignored.
- Simultaneous `fifo_wr` and `fifo_rd` are legal only when the FIFO is neither full nor empty. The FIFO controller drops a write in the wr&rd cycle when empty. This rule holds by construction: a read needs ~empty and a write needs ~full.
- `tx_din` holds its last value outside IDLE→START.

## Timing
- Reset values: `pri`=0, state=IDLE, gap counter=0, `tx_din`=0, `tx_start`=0, `fifo_rd`=0, `busy`=0. `fifo_wr` and `reqN_ready` follow their inputs combinationally.
- Reset mid-frame: the next cycle is IDLE with `tx_start`=0. Any in-flight transmitter frame is abandoned. The FIFO controller shares `reset`.
- Write accepted in cycle W → `fifo_empty` falls at W+1 → `fifo_rd` in W+1 → `tx_start` in W+2.
- Back-to-back frames: IDLE re-entry `GAP_CYC`+1 cycles after `tx_done_tick`, then `tx_start` one cycle later.
- Throughput on the write side is one byte per cycle. Two always-valid requesters alternate 0,1,0,1.

## Structure
- Package `uart_pkg`: `sched_state_t` enum {IDLE, LOAD, START, WAIT, GAP} and the default `DATA_W` constant.
- Sub-module `rr_arb2`: two-way round-robin arbiter with inputs valid[1:0] and en (= ~full), outputs grant[1:0] and the registered `pri`.
- The top level contains the FSM, gap counter and `tx_din` register.

## Test plan
- Reset, then single byte: req0 writes 0xA5 at W → `fifo_rd` at W+1, `tx_start` at W+2 with `tx_din`=0xA5. `tx_done_tick` 10 cycles later with `GAP_CYC`=3 → IDLE after 4 cycles, `busy`=0.
- Contention: both requesters valid continuously with data 0x10.. and 0x20.. → FIFO write order 0x10,0x20,0x11,0x21. Each ready is high every other cycle.
- Full backpressure: with `fifo_full`=1 held and req1 valid → `req1_ready`=0 and `fifo_wr`=0 for all cycles. Release → write in the first cycle `fifo_full`=0.
- Empty boundary: a write in the same cycle as an IDLE check with `fifo_empty`=1 → no `fifo_rd` that cycle. The pop occurs the next cycle; the byte is not lost.
- Spurious done: pulse `tx_done_tick` in IDLE and START → no state change, no extra `tx_start`.
- Reset mid-WAIT: assert `reset` one cycle → state IDLE, `tx_start`=0, `tx_din`=0, `pri`=0 on the following cycle.
